// File: rtl/or1200_vlx_seq_if.sv
// Bus bundle between the VLX store sequencer and its CPU/memory side.
// Signal names keep the sequencer's point of view (_i into it, _o out of it).
interface or1200_vlx_seq_if;
    logic        set_bit_op_i;
    logic [31:0] bits_i;
    logic [4:0]  num_bits_i;
    logic        flush_i;
    logic        init_addr_we_i;
    logic [31:0] init_addr_i;
    logic        ack_i;
    logic        store_byte_o;
    logic [31:0] addr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        stall_cpu_o;
    logic [5:0]  bit_cnt_o;
    logic        err_o;

    // Sequencer side
    modport slave (
        input  set_bit_op_i, bits_i, num_bits_i, flush_i,
        input  init_addr_we_i, init_addr_i, ack_i,
        output store_byte_o, addr_o, dat_o, sel_o, stall_cpu_o, bit_cnt_o, err_o
    );

    // CPU / memory side
    modport master (
        output set_bit_op_i, bits_i, num_bits_i, flush_i,
        output init_addr_we_i, init_addr_i, ack_i,
        input  store_byte_o, addr_o, dat_o, sel_o, stall_cpu_o, bit_cnt_o, err_o
    );
endinterface

// File: rtl/or1200_vlx_seq.sv
// VLX store sequencer: packs variable-length bit fields into a bit buffer
// and emits whole bytes to memory, inserting a 0x00 after every 0xFF byte.
//
// state | meaning
// IDLE  | accepting set-bit / flush / init operations, cnt < 8
// STORE | requesting store of the top buffered byte
// STUFF | requesting store of the 0x00 stuffing byte after an 0xFF
module or1200_vlx_seq (
    input  logic                   clk_i,
    input  logic                   rst_i,
    or1200_vlx_seq_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, STORE, STUFF} state_t;

    state_t      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        store_q, store_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;

    logic [31:0] nb;
    logic [5:0]  nc;
    logic [2:0]  pad;
    logic [7:0]  cur_byte;
    logic        any_op;
    logic        final_ack;

    // Top valid byte of the buffer; only meaningful when c >= 8.
    function automatic logic [7:0] byte_at(input logic [31:0] b, input logic [5:0] c);
        logic [31:0] s;
        s = b >> (c - 6'd8);
        return s[7:0];
    endfunction

    assign cur_byte = byte_at(buf_q, cnt_q);
    assign any_op   = bus.set_bit_op_i | bus.flush_i | bus.init_addr_we_i;

    // Next-state logic for buffer, counter, address, error flag and registered outputs
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        nb      = buf_q;
        nc      = cnt_q;
        pad     = 3'd0;
        case (state_q)
            IDLE: begin
                if (bus.init_addr_we_i) begin
                    addr_d = bus.init_addr_i;
                    buf_d  = 32'h0;
                    cnt_d  = 6'd0;
                    err_d  = bus.set_bit_op_i | bus.flush_i;
                end else if (bus.set_bit_op_i && (bus.num_bits_i > 5'd24)) begin
                    // Illegal length drops the whole operation, including a paired flush.
                    err_d = 1'b1;
                end else begin
                    if (bus.set_bit_op_i && (bus.num_bits_i != 5'd0)) begin
                        nb = (nb << bus.num_bits_i) |
                             (bus.bits_i & ((32'h1 << bus.num_bits_i) - 32'h1));
                        nc = nc + {1'b0, bus.num_bits_i};
                    end
                    if (bus.flush_i) begin
                        pad = 3'd0 - nc[2:0];
                        nb  = (nb << pad) | ((32'h1 << pad) - 32'h1);
                        nc  = nc + {3'b000, pad};
                    end
                    buf_d = nb;
                    cnt_d = nc;
                    if (nc >= 6'd8) state_d = STORE;
                end
            end
            STORE: begin
                if (any_op) err_d = 1'b1;
                if (bus.ack_i) begin
                    addr_d = addr_q + 32'h1;
                    cnt_d  = cnt_q - 6'd8;
                    if (cur_byte == 8'hFF)      state_d = STUFF;
                    else if (cnt_q >= 6'd16)    state_d = STORE;
                    else                        state_d = IDLE;
                end
            end
            STUFF: begin
                if (any_op) err_d = 1'b1;
                if (bus.ack_i) begin
                    addr_d  = addr_q + 32'h1;
                    state_d = (cnt_q >= 6'd8) ? STORE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        store_d = (state_d != IDLE);
        dat_d   = (state_d == STORE) ? {4{byte_at(buf_d, cnt_d)}} : 32'h0;
        sel_d   = store_d ? (4'b1000 >> addr_d[1:0]) : 4'b0000;
    end

    // Ack that ends the current burst of pending bytes
    always_comb begin
        final_ack = 1'b0;
        if (bus.ack_i) begin
            if (state_q == STORE) final_ack = (cur_byte != 8'hFF) && (cnt_q < 6'd16);
            if (state_q == STUFF) final_ack = (cnt_q < 6'd8);
        end
    end

    assign bus.stall_cpu_o = rst_i &&
                             (((state_q != IDLE) && !final_ack) ||
                              ((state_q == IDLE) && (state_d == STORE)));

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            buf_q   <= 32'h0;
            cnt_q   <= 6'd0;
            addr_q  <= 32'h0;
            err_q   <= 1'b0;
            store_q <= 1'b0;
            dat_q   <= 32'h0;
            sel_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            store_q <= store_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.store_byte_o = store_q;
    assign bus.addr_o       = addr_q;
    assign bus.dat_o        = dat_q;
    assign bus.sel_o        = sel_q;
    assign bus.bit_cnt_o    = cnt_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_or1200_vlx_seq.sv
// Directed bench for the VLX store sequencer with a store scoreboard.
module tb_or1200_vlx_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;

    or1200_vlx_seq_if vif();

    or1200_vlx_seq u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        last;
    } store_t;

    store_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] b, input logic [3:0] s,
                        input logic last);
        store_t e;
        e.addr = a;
        e.dat  = {4{b}};
        e.sel  = s;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic clear_ops();
        vif.set_bit_op_i   = 1'b0;
        vif.flush_i        = 1'b0;
        vif.init_addr_we_i = 1'b0;
    endtask

    // Drive one operation for one cycle; stall is checked inside the op cycle.
    task automatic do_op(input string tag, input logic set, input logic [31:0] bits,
                         input logic [4:0] n, input logic fl, input logic init,
                         input logic [31:0] ia, input logic exp_stall);
        vif.set_bit_op_i   = set;
        vif.bits_i         = bits;
        vif.num_bits_i     = n;
        vif.flush_i        = fl;
        vif.init_addr_we_i = init;
        vif.init_addr_i    = ia;
        #1;
        chk({tag, "_stall"}, {31'b0, vif.stall_cpu_o}, {31'b0, exp_stall});
        cyc();
        clear_ops();
    endtask

    // Pop one expected store, compare it, hold ack off for dly cycles, then ack.
    task automatic serve(input string tag, input int dly);
        store_t e;
        int     waited;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        waited = 0;
        while (!vif.store_byte_o && waited < 20) begin
            cyc();
            waited++;
        end
        chk({tag, "_req"},  {31'b0, vif.store_byte_o}, 32'd1);
        chk({tag, "_addr"}, vif.addr_o, e.addr);
        chk({tag, "_dat"},  vif.dat_o, e.dat);
        chk({tag, "_sel"},  {28'b0, vif.sel_o}, {28'b0, e.sel});
        for (int i = 0; i < dly; i++) begin
            cyc();
            chk({tag, "_hold_req"},  {31'b0, vif.store_byte_o}, 32'd1);
            chk({tag, "_hold_dat"},  vif.dat_o, e.dat);
            chk({tag, "_hold_stall"}, {31'b0, vif.stall_cpu_o}, 32'd1);
        end
        vif.ack_i = 1'b1;
        #1;
        chk({tag, "_ack_stall"}, {31'b0, vif.stall_cpu_o}, {31'b0, ~e.last});
        cyc();
        vif.ack_i = 1'b0;
    endtask

    initial begin
        clear_ops();
        vif.bits_i      = 32'h0;
        vif.num_bits_i  = 5'd0;
        vif.init_addr_i = 32'h0;
        vif.ack_i       = 1'b0;

        // Reset
        cyc();
        cyc();
        chk("rst_store", {31'b0, vif.store_byte_o}, 32'd0);
        chk("rst_addr",  vif.addr_o, 32'h0);
        chk("rst_cnt",   {26'b0, vif.bit_cnt_o}, 32'd0);
        chk("rst_err",   {31'b0, vif.err_o}, 32'd0);
        chk("rst_stall", {31'b0, vif.stall_cpu_o}, 32'd0);
        rst = 1'b1;
        cyc();

        // 1: partial field, no store
        do_op("t1_init", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h1000, 1'b0);
        chk("t1_addr", vif.addr_o, 32'h1000);
        do_op("t1_set", 1'b1, 32'h5, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_cnt",   {26'b0, vif.bit_cnt_o}, 32'd3);
        chk("t1_store", {31'b0, vif.store_byte_o}, 32'd0);

        // 2: completes byte 0xBF
        push(32'h1000, 8'hBF, 4'b1000, 1'b1);
        do_op("t2_set", 1'b1, 32'h1F, 5'd5, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_latency", {31'b0, vif.store_byte_o}, 32'd1);
        serve("t2", 0);
        chk("t2_addr",  vif.addr_o, 32'h1001);
        chk("t2_cnt",   {26'b0, vif.bit_cnt_o}, 32'd0);
        chk("t2_idle",  {31'b0, vif.store_byte_o}, 32'd0);
        chk("t2_dat0",  vif.dat_o, 32'h0);

        // 3: 0xFF with stuffing, unaligned start
        do_op("t3_init", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h2003, 1'b0);
        push(32'h2003, 8'hFF, 4'b0001, 1'b0);
        push(32'h2004, 8'h00, 4'b1000, 1'b1);
        do_op("t3_set", 1'b1, 32'hFF, 5'd8, 1'b0, 1'b0, 32'h0, 1'b1);
        serve("t3a", 0);
        serve("t3b", 0);
        chk("t3_addr", vif.addr_o, 32'h2005);

        // 4: flush pads with ones -> 0xFF + stuffing, then empty flush
        do_op("t4_init", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h3000, 1'b0);
        do_op("t4_set", 1'b1, 32'h3, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        push(32'h3000, 8'hFF, 4'b1000, 1'b0);
        push(32'h3001, 8'h00, 4'b0100, 1'b1);
        do_op("t4_flush", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b1);
        serve("t4a", 0);
        serve("t4b", 0);
        chk("t4_cnt", {26'b0, vif.bit_cnt_o}, 32'd0);
        do_op("t4_flush0", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_nostore", {31'b0, vif.store_byte_o}, 32'd0);

        // 5: 24-bit field, delayed acks
        push(32'h3002, 8'h12, 4'b0010, 1'b0);
        push(32'h3003, 8'h34, 4'b0001, 1'b0);
        push(32'h3004, 8'h56, 4'b1000, 1'b1);
        do_op("t5_set", 1'b1, 32'h123456, 5'd24, 1'b0, 1'b0, 32'h0, 1'b1);
        serve("t5a", 3);
        serve("t5b", 3);
        serve("t5c", 3);
        chk("t5_addr", vif.addr_o, 32'h3005);
        chk("t5_idle", {31'b0, vif.store_byte_o}, 32'd0);

        // 6a: illegal length
        do_op("t6_bad", 1'b1, 32'hFFFFFFFF, 5'd25, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_err", {31'b0, vif.err_o}, 32'd1);
        chk("t6_cnt", {26'b0, vif.bit_cnt_o}, 32'd0);
        chk("t6_nostore", {31'b0, vif.store_byte_o}, 32'd0);

        // 6b: reset mid-store, late ack ignored
        do_op("t6_init", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h4000, 1'b0);
        chk("t6_errclr", {31'b0, vif.err_o}, 32'd0);
        do_op("t6_set", 1'b1, 32'hAB, 5'd8, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_req", {31'b0, vif.store_byte_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_stall", {31'b0, vif.stall_cpu_o}, 32'd0);
        cyc();
        chk("t6_rst_store", {31'b0, vif.store_byte_o}, 32'd0);
        chk("t6_rst_addr",  vif.addr_o, 32'h0);
        chk("t6_rst_dat",   vif.dat_o, 32'h0);
        chk("t6_rst_sel",   {28'b0, vif.sel_o}, 32'd0);
        chk("t6_rst_cnt",   {26'b0, vif.bit_cnt_o}, 32'd0);
        chk("t6_rst_err",   {31'b0, vif.err_o}, 32'd0);
        rst = 1'b1;
        vif.ack_i = 1'b1;
        cyc();
        vif.ack_i = 1'b0;
        chk("t6_late_store", {31'b0, vif.store_byte_o}, 32'd0);
        chk("t6_late_addr",  vif.addr_o, 32'h0);
        chk("t6_late_cnt",   {26'b0, vif.bit_cnt_o}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/or1200_vlx_seq.md
# or1200_vlx_seq

Store sequencer for the OR1200 VLX unit. It accumulates variable-length bit fields from set-bit operations into a 32-bit bit buffer and emits whole bytes to memory, one store handshake at a time. It inserts JPEG 0x00 stuffing after every 0xFF byte and pads with 1s on flush. It drives the CPU stall so the pipeline never issues a new VLX operation while bytes are still pending.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- set_bit_op_i  in  1  one-cycle pulse: append bits_i[num_bits_i-1:0]
- bits_i  in  32  right-aligned bit field; bits above num_bits_i ignored
- num_bits_i  in  5  field length, legal 0..24 (0 = no-op)
- flush_i  in  1  one-cycle pulse: pad buffer with 1s to a byte boundary, then emit
- init_addr_we_i  in  1  load store address; also clears buffer and err_o
- init_addr_i  in  32  new store address
- ack_i  in  1  memory store acknowledge
- store_byte_o  out  1  store request, held until ack_i
- addr_o  out  32  byte address of the current or next store
- dat_o  out  32  byte replicated on all four lanes
- sel_o  out  4  big-endian lane select, 4'b1000 >> addr_o[1:0]
- stall_cpu_o  out  1  CPU stall (combinational)
- bit_cnt_o  out  6  valid bits currently in buffer
- err_o  out  1  sticky protocol error

## Operation
- Internal state: buf[31:0], cnt[5:0], state ∈ {IDLE, STORE, STUFF}.
- IDLE, set_bit_op_i with 1≤n≤24:
  - buf ← (buf << n) | (bits_i & ((1<<n)-1))
  - cnt ← cnt+n
  - If new cnt ≥ 8, go to STORE.
- IDLE, flush_i:
  - pad p = (8 − cnt mod 8) mod 8.
  - buf ← (buf << p) | ((1<<p)−1).
  - cnt ← cnt+p.
  - If result ≥ 8, go to STORE. cnt=0 is a no-op.
- Simultaneous set_bit_op_i and flush_i in IDLE: the bits are appended first, then padding is applied, in the same cycle.
- Current byte B = buf[cnt-1 -: 8].
- STORE:
  - store_byte_o=1, dat_o={B,B,B,B}.
  - On ack_i: addr+1 and cnt−8.
  - Next state: STUFF if B==8'hFF, else STORE if cnt−8 ≥ 8, else IDLE.
- STUFF:
  - store_byte_o=1, dat_o=0.
  - On ack_i: addr+1.
  - Next state: STORE if cnt ≥ 8, else IDLE.
- init_addr_we_i in IDLE: addr ← init_addr_i, buf ← 0, cnt ← 0, err_o ← 0. It has priority over set_bit_op_i/flush_i in the same cycle; those are dropped and err_o is set.
- Conditions that set err_o with no other state change:
  - num_bits_i > 24
  - any of set_bit_op_i, flush_i or init_addr_we_i while state ≠ IDLE
- Invariants:
  - cnt < 8 whenever state = IDLE.
  - Maximum cnt is 7+24 = 31; after padding it is at most 32, which fits the 6-bit counter and 32-bit buffer.
- addr_o wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rst_i=0 at an edge) from any state:
  - state IDLE, buf/cnt/addr cleared.
  - store_byte_o=0, addr_o=0, dat_o=0, sel_o=0, bit_cnt_o=0, err_o=0.
  - stall_cpu_o=0 once rst_i is low.
  - An in-flight store is abandoned; a late ack_i is ignored in IDLE.
- Latency: an operation accepted in cycle 0 raises store_byte_o in cycle 1.
- store_byte_o, addr_o, dat_o and sel_o are registered and stable until the ack cycle.
- Back-to-back bytes: store_byte_o stays high across acks; the address and data change on the cycle after each ack.
- stall_cpu_o = (state≠IDLE and not final-ack) or (IDLE and accepted op makes cnt ≥ 8).
  - Final-ack: ack_i in STORE with B≠FF and cnt−8 < 8, or ack_i in STUFF with cnt < 8.
  - Effect: stall drops in the cycle of the last ack, and the CPU resumes the cycle after.
- dat_o and sel_o are meaningful only while store_byte_o=1. They return to 0 in IDLE.

## Test plan
1. Reset; init_addr 0x1000; set_bit bits=0x5, n=3 -> no store, bit_cnt_o=3, stall_cpu_o=0 throughout.
2. Continue with bits=0x1F, n=5 -> stall high in the op cycle; store at 0x1000, dat_o=0xBFBFBFBF, sel_o=4'b1000. Stall low in the ack cycle; addr_o=0x1001, bit_cnt_o=0.
3. init 0x2003; bits=0xFF, n=8 -> store 0xFF at 0x2003 (sel 0001), then 0x00 at 0x2004 (sel 1000); final addr_o=0x2005.
4. init 0x3000; bits=0x3, n=2, then flush -> store 0xFF at 0x3000, stuff 0x00 at 0x3001, bit_cnt_o=0; flush with cnt=0 -> no store.
5. bits=0x123456, n=24, ack_i delayed 3 cycles per byte -> bytes 0x12, 0x34, 0x56 at consecutive addresses. store_byte_o stays high between them; stall low only in the third ack cycle.
6. Two error/reset checks:
   - n=25 set_bit -> err_o=1, bit_cnt_o unchanged.
   - rst_i low mid-STORE -> all outputs 0 next cycle; a following ack_i has no effect.
